// File: rtl/word_tx_buffer.sv
// Guess-word buffer between the keypad FSM and the UART transmitter.
// Collects A..Z letters, shows them, and streams the word plus a terminator on submit.
module word_tx_buffer #(
  parameter int unsigned MAX_LEN   = 5,
  parameter logic [7:0]  TERM_BYTE = 8'h0A,
  parameter logic [7:0]  EOT_BYTE  = 8'h04
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   letter_valid,
  input  logic [7:0]             letter,
  input  logic                   word_submit,
  input  logic                   game_end,
  input  logic                   tx_ready,
  output logic [7:0]             txdata,
  output logic                   tx_strobe,
  output logic [8*MAX_LEN-1:0]   word_out,
  output logic [3:0]             count,
  output logic                   busy,
  output logic                   overflow,
  output logic                   done
);

  localparam logic [7:0] EMPTY_SLOT = 8'h5F;
  localparam logic [3:0] MAX_CNT    = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    COLLECT,
    SEND,
    GAP,
    SEND_TERM,
    SEND_EOT,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] slot_q [MAX_LEN];
  logic [7:0] slot_d [MAX_LEN];
  logic [3:0] count_q, count_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] txdata_q, txdata_d;
  logic       strobe_q, strobe_d;
  logic       ovf_q, ovf_d;

  logic       is_alpha;
  logic       abandon;
  logic [7:0] cur_byte;

  assign is_alpha = (letter >= 8'h41) && (letter <= 8'h5A);
  assign abandon  = game_end && ((state_q == COLLECT) || (state_q == SEND) ||
                                 (state_q == GAP)     || (state_q == SEND_TERM));

  // Mux by comparison keeps the slot select legal for every MAX_LEN, including 1.
  always_comb begin
    cur_byte = EMPTY_SLOT;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (idx_q == 4'(i)) cur_byte = slot_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= COLLECT;
      count_q  <= '0;
      idx_q    <= '0;
      txdata_q <= '0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) slot_q[i] <= EMPTY_SLOT;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      txdata_q <= txdata_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
      for (int unsigned i = 0; i < MAX_LEN; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    txdata_d = txdata_q;
    strobe_d = 1'b0;
    ovf_d    = ovf_q;
    for (int unsigned i = 0; i < MAX_LEN; i++) slot_d[i] = slot_q[i];

    if (abandon) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) slot_d[i] = EMPTY_SLOT;
      count_d = '0;
      state_d = SEND_EOT;
    end else begin
      case (state_q)
        COLLECT: begin
          if (letter_valid && is_alpha) begin
            if (count_q < MAX_CNT) begin
              for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (count_q == 4'(i)) slot_d[i] = letter;
              end
              count_d = count_q + 4'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          // count_d already includes a letter arriving in the same cycle.
          if (word_submit && (count_d != 4'd0)) begin
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            txdata_d = cur_byte;
            strobe_d = 1'b1;
            idx_d    = idx_q + 4'd1;
            state_d  = GAP;
          end
        end
        GAP: begin
          state_d = (idx_q < count_q) ? SEND : SEND_TERM;
        end
        SEND_TERM: begin
          if (tx_ready) begin
            txdata_d = TERM_BYTE;
            strobe_d = 1'b1;
            count_d  = '0;
            ovf_d    = 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) slot_d[i] = EMPTY_SLOT;
            state_d  = COLLECT;
          end
        end
        SEND_EOT: begin
          if (tx_ready) begin
            txdata_d = EOT_BYTE;
            strobe_d = 1'b1;
            state_d  = DONE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = COLLECT;
        end
      endcase
    end
  end

  always_comb begin
    busy     = (state_q == SEND) || (state_q == GAP) ||
               (state_q == SEND_TERM) || (state_q == SEND_EOT);
    done     = (state_q == DONE);
    word_out = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) word_out[8*i +: 8] = slot_q[i];
  end

  assign txdata    = txdata_q;
  assign tx_strobe = strobe_q;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/word_tx_buffer.md
# word_tx_buffer

Collects letters confirmed by the keypad FSM into a fixed-length guess buffer, shows the buffer on the displays, and on word submission streams the letters out the UART transmit port as bytes, followed by a terminator. It sits directly downstream of the keypad FSM, taking its letter-ready pulse, ASCII byte, word-submit pulse and game-end pulse, and directly upstream of the UART transmitter in the top level.

## Interface

Parameters:
- MAX_LEN, default 5: buffer depth in letters (1–8).
- TERM_BYTE, default 8'h0A: byte sent after the last letter of a word.
- EOT_BYTE, default 8'h04: byte sent on game end.

Ports:
- clk  input  1  system clock (10 MHz). One clock domain only.
- reset  input  1  asynchronous, active-high reset.
- letter_valid  input  1  one-cycle pulse; letter is valid (FSM ready).
- letter  input  8  ASCII letter (FSM data).
- word_submit  input  1  one-cycle pulse; send the buffered word (FSM toggle_state).
- game_end  input  1  one-cycle pulse; end of game.
- tx_ready  input  1  UART can accept a byte.
- txdata  output  8  byte to transmit; registered.
- tx_strobe  output  1  one-cycle load pulse to the UART (drives txclk); registered.
- word_out  output  8*MAX_LEN  buffer contents; slot 0 is in bits [7:0]; an empty slot reads 8'h5F ('_').
- count  output  4  number of letters buffered, 0..MAX_LEN.
- busy  output  1  high in SEND, GAP, SEND_TERM and SEND_EOT.
- overflow  output  1  sticky; a letter was dropped because the buffer was full.
- done  output  1  high in DONE.

## Operation

States are COLLECT, SEND, GAP, SEND_TERM, SEND_EOT and DONE.

- **Reset values:** state COLLECT, txdata 0, tx_strobe 0, count 0, every slot 8'h5F, busy 0, overflow 0, done 0, idx 0.
- **COLLECT:**
  - On letter_valid with letter in 65..90 and count < MAX_LEN: slot[count] ← letter, and count increments.
  - On letter_valid with a non-letter value: the letter is dropped and no flag is set.
  - On letter_valid while count == MAX_LEN: the letter is dropped and overflow ← 1.
  - On word_submit with count > 0: idx ← 0, go to SEND.
  - On word_submit with count == 0: ignored.
- **SEND:**
  - If tx_ready: txdata ← slot[idx], tx_strobe ← 1, idx increments, go to GAP.
  - Otherwise hold; waiting has no timeout.
- **GAP:**
  - Lasts one cycle, and tx_ready is ignored during it.
  - If idx < count, go to SEND; otherwise go to SEND_TERM.
- **SEND_TERM:**
  - If tx_ready: txdata ← TERM_BYTE, tx_strobe ← 1.
  - In the same cycle: count ← 0, every slot ← 8'h5F, overflow ← 0, go to COLLECT.
- **SEND_EOT:**
  - If tx_ready: txdata ← EOT_BYTE, tx_strobe ← 1, go to DONE.
- **DONE:** all inputs are ignored until reset.
- **game_end:**
  - Has priority over every other input in COLLECT, SEND, GAP and SEND_TERM.
  - Abandons any word in progress, clears the buffer and count, and goes to SEND_EOT.
  - Ignored in SEND_EOT and DONE.
- **Inputs while busy:** letter_valid and word_submit arriving in any busy state are dropped and do not set overflow.
- **letter_valid and word_submit in the same COLLECT cycle:** the letter is stored first, and the word sent includes it. This holds even if the buffer was empty beforehand.
- **tx_strobe:** zero in every cycle except a single load cycle. txdata holds its last value between strobes.

## Timing

- A letter_valid sampled at edge N makes count and word_out update in the cycle after edge N.
- A word_submit sampled at edge N puts the block in SEND after N.
- If tx_ready is high, the first tx_strobe is asserted after edge N+1.
- Per byte the minimum is 2 cycles (SEND plus GAP). A word of k letters plus the terminator takes at least 2k+1 cycles with tx_ready held high.
- busy rises in the same cycle the state leaves COLLECT. It falls after the terminator strobe edge.
- Reset asserted mid-transmission forces tx_strobe to 0 and every output to its reset value immediately; this is asynchronous. No partial byte is retried.

## Test plan

- **Basic word:** after reset, letters 'C', 'A', 'T' then word_submit, tx_ready held at 1 → strobes carry 8'h43, 8'h41, 8'h54, 8'h0A on cycles spaced 2 apart; after the last strobe, count is 0 and word_out is all 8'h5F.
- **Overflow:** 6 letters 'A'..'F' with MAX_LEN=5 → count 5, overflow 1, slot 4 = 'E'; submit sends A..E then 0A, after which overflow is 0.
- **Backpressure and dropped input:** submit 2 letters with tx_ready at 0 for 10 cycles → no strobe and busy=1; a letter pulse during the wait leaves count unchanged; raising tx_ready then produces the 3 bytes.
- **Empty submit and invalid letter:** word_submit with count 0 → no strobe and state stays COLLECT; letter 8'h5F → count stays 0.
- **Game end mid-word:** game_end during GAP of a 3-letter send → next strobe carries 8'h04, done=1, and later letters and submits produce nothing.
- **Simultaneous events and reset:** letter_valid and word_submit in the same cycle on an empty buffer → that 1 letter then 0A are sent; asynchronous reset during SEND → tx_strobe is 0 immediately and all outputs take their reset values.
